// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared FSM encoding and default counter width for pulse_meter
package pulse_meter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pm_state_e;
  localparam int PM_W = 8;
endpackage

// File: rtl/pulse_meter_edge_detect.sv
// edge_detect: registers the input line and flags its sampled rising edges
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic signal,
  output logic rise
);
  logic sig_q;
  // history register resets high so a line already high at reset release is not an edge
  always_ff @(posedge clock)
    sig_q <= reset ? 1'b1 : signal;
  assign rise = signal & ~sig_q;
endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time and rise-to-rise period of a pulse train, publishes via valid/ack
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int W = PM_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         on,
  input  logic         signal,
  input  logic         ack,
  output logic [W-1:0] width,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         sat,
  output logic         overrun
);
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);
  pm_state_e   state_q, state_d;
  logic [W-1:0] wcnt_q, wcnt_d, pcnt_q, pcnt_d, width_q, width_d, period_q, period_d;
  logic         flag_q, flag_d, valid_q, valid_d, sat_q, sat_d, overrun_q, overrun_d;
  logic         rise, pub, load;
  logic [W-1:0] winc, pinc;
  edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .signal(signal),
    .rise  (rise)
  );
  assign winc = (wcnt_q == MAX) ? MAX : wcnt_q + ONE;
  assign pinc = (pcnt_q == MAX) ? MAX : pcnt_q + ONE;
  // measurement FSM: counts high time and period, emits pub on the terminating rise
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pcnt_q;
    flag_d  = flag_q;
    pub     = 1'b0;
    if (!on) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (rise) begin
          state_d = HIGH;
          wcnt_d  = ONE;
          pcnt_d  = ONE;
          flag_d  = 1'b0;
        end
        HIGH: begin
          pcnt_d  = pinc;
          wcnt_d  = signal ? winc : wcnt_q;
          flag_d  = flag_q | (pinc == MAX) | (signal & (winc == MAX));
          state_d = signal ? HIGH : LOW;
        end
        LOW: if (rise) begin
          pub     = 1'b1;
          state_d = HIGH;
          wcnt_d  = ONE;
          pcnt_d  = ONE;
          flag_d  = 1'b0;
        end else begin
          pcnt_d = pinc;
          flag_d = flag_q | (pinc == MAX);
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // result registers: a pending unacked result blocks new ones and raises the sticky overrun
  always_comb begin
    load      = pub & (~valid_q | ack);
    valid_d   = pub | (valid_q & ~ack);
    overrun_d = overrun_q | (pub & valid_q & ~ack);
    width_d   = load ? wcnt_q : width_q;
    period_d  = load ? pcnt_q : period_q;
    sat_d     = load ? flag_q : sat_q;
  end
  // state and result registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
      flag_q    <= 1'b0;
      width_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      pcnt_q    <= pcnt_d;
      flag_q    <= flag_d;
      width_q   <= width_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end
  assign width   = width_q;
  assign period  = period_q;
  assign valid   = valid_q;
  assign sat     = sat_q;
  assign overrun = overrun_q;
endmodule
